// File: rtl/req_encoder_if.sv
// Handshake bundle for req_encoder: request-vector input side, index output side and status.
interface req_encoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_vec;
  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ready;
  logic             zero_in;
  logic             busy;

  // Drives requests and consumes indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_in, busy
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_in, busy
  );
endinterface

// File: rtl/req_encoder.sv
// Sequential 8-to-3 request encoder: captures a request vector and emits the
// index of every set bit, lowest first, one per output handshake.
module req_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  req_encoder_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic             zero_q;
  logic [IDX_W-1:0] idx_c;
  logic             last_c;
  logic             in_hs;
  logic             out_hs;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid && (bus.in_vec != '0)) state_nxt = EMIT;
      EMIT:    if (bus.out_ready && last_c)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE:    bus.in_ready = 1'b1;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign in_hs  = bus.in_valid  && (state == IDLE);
  assign out_hs = bus.out_ready && (state == EMIT);

  // Priority encode, scanning downward so the lowest set bit wins
  always_comb begin
    idx_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) idx_c = IDX_W'(i);
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest bit leaves zero
  assign last_c = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                           pending <= '0;
    else if (in_hs && (bus.in_vec != '0)) pending <= bus.in_vec;
    else if (out_hs)                      pending <= pending & ~(WIDTH'(1) << idx_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= in_hs && (bus.in_vec == '0);
  end

  assign bus.out_idx  = idx_c;
  assign bus.out_last = last_c;
  assign bus.zero_in  = zero_q;

endmodule
